// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with per-register scoreboard (busy) bits.
//
// Holds 2**ADDR_W registers of DATA_W bits. Each register carries a busy bit
// that marks a pending writeback: an issue sets it, a write clears it.
// Reads are combinational, with optional forwarding of the write port's data
// in the same cycle. busyCount is a registered population count of the busy
// bits, updated on the same edge as the bits themselves.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads as zero, never busy, ignores writes/issues
//   BYPASS    1: same-cycle write data is forwarded to matching read ports
//
// Ports
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   rdAddr1/rdAddr2     read addresses
//   rdData1/rdData2     combinational read data
//   rdBusy1/rdBusy2     combinational busy flag of the addressed register
//   wrEn/wrAddr/wrData  write port (clears busy of the target)
//   issueEn/issueAddr   marks the destination register busy
//   flush               clears every busy bit (data untouched)
//   busyCount           registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic              rdBusy1,
  output logic              rdBusy2,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              issueEn,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic              flush,
  output logic [ADDR_W:0]   busyCount
);

  localparam int DEPTH = 1 << ADDR_W;

  // Flattened views of the per-register state, each element driven by
  // exactly one generate block below.
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic              busy_q   [DEPTH];
  logic              busy_nxt [DEPTH];

  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;

  // ---------------------------------------------------------------------------
  // Per-register storage and busy-bit update
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        // Hardwired zero register: no storage at all.
        assign data_q[gi]   = '0;
        assign busy_q[gi]   = 1'b0;
        assign busy_nxt[gi] = 1'b0;
      end else begin : g_live
        logic [DATA_W-1:0] data_reg;
        logic              busy_reg;
        logic              busy_next;
        logic              wr_hit;
        logic              issue_hit;

        assign wr_hit    = wrEn    && (wrAddr    == ADDR_W'(gi));
        assign issue_hit = issueEn && (issueAddr == ADDR_W'(gi));

        // Priority: flush clears everything, then a new issue beats a
        // completing write to the same register, then the write clears.
        always_comb begin
          busy_next = busy_reg;
          if (flush) begin
            busy_next = 1'b0;
          end else if (issue_hit) begin
            busy_next = 1'b1;
          end else if (wr_hit) begin
            busy_next = 1'b0;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_hit) begin
              data_reg <= wrData;
            end
            busy_reg <= busy_next;
          end
        end

        assign data_q[gi]   = data_reg;
        assign busy_q[gi]   = busy_reg;
        assign busy_nxt[gi] = busy_next;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Busy count: a popcount of the next-state busy bits, registered alongside
  // them. Recomputing rather than incrementing/decrementing means the count
  // can never drift, wrap or underflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + (ADDR_W + 1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign busyCount = count_reg;

  // ---------------------------------------------------------------------------
  // Read ports. Forwarding never applies to the hardwired zero register.
  // ---------------------------------------------------------------------------
  logic wr_is_zero;
  logic fwd1;
  logic fwd2;

  assign wr_is_zero = (ZERO_REG != 0) && (wrAddr == '0);
  assign fwd1 = (BYPASS != 0) && wrEn && !wr_is_zero && (wrAddr == rdAddr1);
  assign fwd2 = (BYPASS != 0) && wrEn && !wr_is_zero && (wrAddr == rdAddr2);

  assign rdData1 = fwd1 ? wrData : data_q[rdAddr1];
  assign rdData2 = fwd2 ? wrData : data_q[rdAddr2];
  assign rdBusy1 = fwd1 ? 1'b0   : busy_q[rdAddr1];
  assign rdBusy2 = fwd2 ? 1'b0   : busy_q[rdAddr2];

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed self-checking bench for regfile_sb.
// Two instances share all inputs: "b" uses the defaults (ZERO_REG=1, BYPASS=1),
// "n" uses ZERO_REG=0, BYPASS=0.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rdAddr1, rdAddr2, wrAddr, issueAddr;
  logic [15:0] wrData;
  logic        wrEn, issueEn, flush;

  logic [15:0] rd_data1_b, rd_data2_b, rd_data1_n, rd_data2_n;
  logic        rd_busy1_b, rd_busy2_b, rd_busy1_n, rd_busy2_n;
  logic [3:0]  count_b, count_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut_b (
    .clk(clk), .rst_n(rst_n),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
    .rdData1(rd_data1_b), .rdData2(rd_data2_b),
    .rdBusy1(rd_busy1_b), .rdBusy2(rd_busy2_b),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .issueEn(issueEn), .issueAddr(issueAddr),
    .flush(flush), .busyCount(count_b)
  );

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
    .rdData1(rd_data1_n), .rdData2(rd_data2_n),
    .rdBusy1(rd_busy1_n), .rdBusy2(rd_busy2_n),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .issueEn(issueEn), .issueAddr(issueAddr),
    .flush(flush), .busyCount(count_n)
  );

  // Drive all strobes idle.
  task automatic idle();
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    issueEn = 1'b0; issueAddr = '0; flush = 1'b0;
  endtask

  // Advance one rising edge; inputs may change 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdAddr1 = 3'd0; rdAddr2 = 3'd7;
    idle();
    step();
    #1;
    checks++;
    if (count_b !== 4'd0 || count_n !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: got b=%0d n=%0d expected 0", count_b, count_n);
    end
    for (int a = 0; a < 8; a++) begin
      rdAddr1 = 3'(a);
      #1;
      checks++;
      if (rd_data1_b !== 16'h0 || rd_busy1_b !== 1'b0 ||
          rd_data1_n !== 16'h0 || rd_busy1_n !== 1'b0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got b=%h/%b n=%h/%b expected 0000/0",
                 a, rd_data1_b, rd_busy1_b, rd_data1_n, rd_busy1_n);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_bypass();
    rdAddr1 = 3'd3;
    wrEn = 1'b1; wrAddr = 3'd3; wrData = 16'h1234;
    #1;
    checks++;
    if (rd_data1_b !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 1234", rd_data1_b);
    end
    checks++;
    if (rd_data1_n !== 16'h0000) begin
      errors++;
      $display("FAIL nobypass_old_value: got %h expected 0000", rd_data1_n);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data1_b !== 16'h1234 || rd_data1_n !== 16'h1234) begin
      errors++;
      $display("FAIL write_r3_next: got b=%h n=%h expected 1234", rd_data1_b, rd_data1_n);
    end
    $display("write r3=1234 bypass=%h nobypass=%h", rd_data1_b, rd_data1_n);
  endtask

  task automatic test_issue_write();
    issueEn = 1'b1; issueAddr = 3'd5;
    step();
    idle();
    rdAddr2 = 3'd5;
    #1;
    checks++;
    if (rd_busy2_b !== 1'b1 || count_b !== 4'd1 || rd_busy2_n !== 1'b1 || count_n !== 4'd1) begin
      errors++;
      $display("FAIL issue_r5: got busy b=%b n=%b count b=%0d n=%0d expected 1/1",
               rd_busy2_b, rd_busy2_n, count_b, count_n);
    end
    wrEn = 1'b1; wrAddr = 3'd5; wrData = 16'h00AA;
    #1;
    checks++;
    if (rd_busy2_b !== 1'b0 || rd_data2_b !== 16'h00AA || rd_busy2_n !== 1'b1) begin
      errors++;
      $display("FAIL write_r5_fwd: got b=%h/%b n_busy=%b expected 00aa/0 n_busy=1",
               rd_data2_b, rd_busy2_b, rd_busy2_n);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_busy2_b !== 1'b0 || rd_data2_b !== 16'h00AA || count_b !== 4'd0 ||
        rd_busy2_n !== 1'b0 || rd_data2_n !== 16'h00AA || count_n !== 4'd0) begin
      errors++;
      $display("FAIL write_r5_done: got b=%h/%b/%0d n=%h/%b/%0d expected 00aa/0/0",
               rd_data2_b, rd_busy2_b, count_b, rd_data2_n, rd_busy2_n, count_n);
    end
    $display("issue+write r5 count=%0d", count_b);
  endtask

  task automatic test_same_edge();
    issueEn = 1'b1; issueAddr = 3'd2;
    wrEn = 1'b1; wrAddr = 3'd2; wrData = 16'h0007;
    step();
    idle();
    rdAddr1 = 3'd2;
    #1;
    checks++;
    if (rd_data1_b !== 16'h0007 || rd_busy1_b !== 1'b1 || count_b !== 4'd1 ||
        rd_data1_n !== 16'h0007 || rd_busy1_n !== 1'b1 || count_n !== 4'd1) begin
      errors++;
      $display("FAIL same_edge_r2: got b=%h/%b/%0d n=%h/%b/%0d expected 0007/1/1",
               rd_data1_b, rd_busy1_b, count_b, rd_data1_n, rd_busy1_n, count_n);
    end
    $display("same-edge issue+write r2 count=%0d", count_b);
  endtask

  task automatic test_zero_reg();
    rdAddr1 = 3'd0;
    wrEn = 1'b1; wrAddr = 3'd0; wrData = 16'hFFFF;
    issueEn = 1'b1; issueAddr = 3'd0;
    #1;
    checks++;
    if (rd_data1_b !== 16'h0 || rd_busy1_b !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_fwd: got %h/%b expected 0000/0", rd_data1_b, rd_busy1_b);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data1_b !== 16'h0 || rd_busy1_b !== 1'b0 || count_b !== 4'd1) begin
      errors++;
      $display("FAIL zero_reg: got %h/%b/%0d expected 0000/0/1", rd_data1_b, rd_busy1_b, count_b);
    end
    checks++;
    if (rd_data1_n !== 16'hFFFF || rd_busy1_n !== 1'b1 || count_n !== 4'd2) begin
      errors++;
      $display("FAIL plain_r0: got %h/%b/%0d expected ffff/1/2", rd_data1_n, rd_busy1_n, count_n);
    end
    $display("r0 write+issue b=%h n=%h", rd_data1_b, rd_data1_n);
  endtask

  task automatic test_flush();
    // r2 is already busy, so re-issuing it must not change the count.
    for (int i = 1; i < 8; i++) begin
      issueEn = 1'b1; issueAddr = 3'(i);
      step();
    end
    idle();
    #1;
    checks++;
    if (count_b !== 4'd7 || count_n !== 4'd8) begin
      errors++;
      $display("FAIL fill_count: got b=%0d n=%0d expected 7/8", count_b, count_n);
    end
    flush = 1'b1; issueEn = 1'b1; issueAddr = 3'd1;
    wrEn = 1'b1; wrAddr = 3'd4; wrData = 16'h4444;
    step();
    idle();
    #1;
    checks++;
    if (count_b !== 4'd0 || count_n !== 4'd0) begin
      errors++;
      $display("FAIL flush_count: got b=%0d n=%0d expected 0", count_b, count_n);
    end
    for (int a = 1; a < 8; a++) begin
      logic [15:0] exp_d;
      case (a)
        2: exp_d = 16'h0007;
        3: exp_d = 16'h1234;
        4: exp_d = 16'h4444;
        5: exp_d = 16'h00AA;
        default: exp_d = 16'h0000;
      endcase
      rdAddr1 = 3'(a);
      #1;
      checks++;
      if (rd_busy1_b !== 1'b0 || rd_data1_b !== exp_d ||
          rd_busy1_n !== 1'b0 || rd_data1_n !== exp_d) begin
        errors++;
        $display("FAIL flush_read[%0d]: got b=%h/%b n=%h/%b expected %h/0",
                 a, rd_data1_b, rd_busy1_b, rd_data1_n, rd_busy1_n, exp_d);
      end
    end
    // Write to a non-busy register must not decrement the count.
    wrEn = 1'b1; wrAddr = 3'd6; wrData = 16'h0066;
    step();
    idle();
    rdAddr1 = 3'd6;
    #1;
    checks++;
    if (count_b !== 4'd0 || rd_busy1_b !== 1'b0 || rd_data1_b !== 16'h0066) begin
      errors++;
      $display("FAIL nonbusy_write: got %h/%b/%0d expected 0066/0/0", rd_data1_b, rd_busy1_b, count_b);
    end
    $display("flush done count=%0d", count_b);
  endtask

  task automatic test_back_to_back();
    issueEn = 1'b1; issueAddr = 3'd1;
    wrEn = 1'b1; wrAddr = 3'd6; wrData = 16'h6666;
    step();
    rdAddr1 = 3'd1; rdAddr2 = 3'd6;
    issueAddr = 3'd7;
    wrAddr = 3'd1; wrData = 16'h1111;
    // Before the second edge: r1 busy from the first edge, r6 written.
    checks++;
    if (rd_busy1_n !== 1'b1 || rd_data2_n !== 16'h6666 || count_b !== 4'd1 || count_n !== 4'd1) begin
      errors++;
      $display("FAIL diff_addr: got r1busy=%b r6=%h count b=%0d n=%0d expected 1/6666/1/1",
               rd_busy1_n, rd_data2_n, count_b, count_n);
    end
    step();
    idle();
    rdAddr2 = 3'd7;
    #1;
    checks++;
    if (count_b !== 4'd1 || rd_busy1_b !== 1'b0 || rd_data1_b !== 16'h1111 || rd_busy2_b !== 1'b1) begin
      errors++;
      $display("FAIL b2b: got r1=%h/%b r7busy=%b count=%0d expected 1111/0/1/1",
               rd_data1_b, rd_busy1_b, rd_busy2_b, count_b);
    end
    $display("back-to-back count=%0d", count_b);
  endtask

  task automatic test_midrun_reset();
    wrEn = 1'b1; wrAddr = 3'd3; wrData = 16'hBEEF;
    issueEn = 1'b1; issueAddr = 3'd3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count_b !== 4'd0 || count_n !== 4'd0) begin
      errors++;
      $display("FAIL midrun_count: got b=%0d n=%0d expected 0", count_b, count_n);
    end
    step();
    idle();
    for (int a = 0; a < 8; a++) begin
      rdAddr1 = 3'(a);
      #1;
      checks++;
      if (rd_data1_b !== 16'h0 || rd_busy1_b !== 1'b0 ||
          rd_data1_n !== 16'h0 || rd_busy1_n !== 1'b0) begin
        errors++;
        $display("FAIL midrun_read[%0d]: got b=%h/%b n=%h/%b expected 0000/0",
                 a, rd_data1_b, rd_busy1_b, rd_data1_n, rd_busy1_n);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rdAddr1 = 3'd3;
    #1;
    checks++;
    if (rd_data1_b !== 16'h0 || count_b !== 4'd0) begin
      errors++;
      $display("FAIL post_reset: got %h/%0d expected 0000/0", rd_data1_b, count_b);
    end
    $display("mid-run reset count=%0d", count_b);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_issue_write();
    test_same_edge();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
